gray_counter: RTL

//   Synchronous up/down Gray-code counter; the source stage for gray_to_bin.

---
 rtl/gray_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//   Synchronous up/down Gray-code counter. A binary count is kept internally,
//   and its Gray encoding is registered on the same edge. Between counted steps
//   exactly one Gray bit changes, so gray_o can safely cross a clock domain
//   through a synchronizer and be decoded downstream by gray_to_bin.
//
// Parameters
//   WIDTH      counter width in bits (>= 2)
//   SATURATE   0: wrap at the terminal value, 1: hold at the terminal value
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset (overrides load and en)
//   en_i         count-step request
//   up_i         direction: 1 = increment, 0 = decrement
//   load_i       load request (priority over en_i)
//   load_bin_i   binary value to load
//   gray_o       registered Gray code of the count
//   bin_o        registered binary count
//   tc_o         combinational terminal count for the current direction
//   wrapped_o    registered one-cycle pulse on the edge the count wrapped
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_bin_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             tc_o,
  output logic             wrapped_o
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Binary to reflected Gray code.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrapped_q, wrapped_d;
  logic             at_term_s;
  logic [WIDTH-1:0] step_s;

  // Terminal detection and the candidate stepped value for the current direction.
  always_comb begin
    at_term_s = 1'b0;
    step_s    = bin_q;
    if (up_i) begin
      at_term_s = (bin_q == MAX_VAL);
      step_s    = bin_q + ONE_VAL;
    end else begin
      at_term_s = (bin_q == ZERO_VAL);
      step_s    = bin_q - ONE_VAL;
    end
  end

  // Next-state selection: load > en > hold (reset handled in the register).
  always_comb begin
    bin_d     = bin_q;
    wrapped_d = 1'b0;
    if (load_i) begin
      bin_d     = load_bin_i;
      wrapped_d = 1'b0;
    end else if (en_i) begin
      if (at_term_s && SATURATE) begin
        // Saturating counter parks at the terminal value; no wrap indication.
        bin_d     = bin_q;
        wrapped_d = 1'b0;
      end else begin
        bin_d     = step_s;
        wrapped_d = at_term_s;
      end
    end else begin
      bin_d     = bin_q;
      wrapped_d = 1'b0;
    end
    // Gray is derived from the same next value so bin and gray never disagree.
    gray_d = bin2gray(bin_d);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q     <= ZERO_VAL;
      gray_q    <= ZERO_VAL;
      wrapped_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign gray_o    = gray_q;
  assign bin_o     = bin_q;
  assign wrapped_o = wrapped_q;
  assign tc_o      = at_term_s;

endmodule
